// File: rtl/reservation_station_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reservation_station_pkg                                    |
// | Desc    : Shared widths, READY tag, station tag bases, age helper.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package reservation_station_pkg;

    localparam int WORD_SIZE = 32;
    localparam int FU_INDEX  = 4;
    localparam int OP_WIDTH  = 4;
    localparam int AGE_W     = 3;
    localparam int RS_DEPTH  = 4;

    typedef logic [FU_INDEX-1:0] fu_tag_t;
    localparam fu_tag_t READY = '0;

    // Each station owns a contiguous tag range starting at its base.
    localparam int RS_ALU_BASE_TAG = 1;
    localparam int RS_MUL_BASE_TAG = 5;
    localparam int RS_MEM_BASE_TAG = 9;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age,
                                                 input logic [AGE_W-1:0] age_max);
        return (age >= age_max) ? age : age + AGE_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reservation_station_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reservation_station_if                                     |
// | Desc    : Issue, CDB snoop and FU dispatch bundle of the station.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface reservation_station_if #(
    parameter int WORD_SIZE = reservation_station_pkg::WORD_SIZE,
    parameter int FU_INDEX  = reservation_station_pkg::FU_INDEX,
    parameter int OP_WIDTH  = reservation_station_pkg::OP_WIDTH
);
    logic                 issue_valid;
    logic                 issue_ready;
    logic [OP_WIDTH-1:0]  issue_op;
    logic [WORD_SIZE-1:0] issue_vj;
    logic [WORD_SIZE-1:0] issue_vk;
    logic [FU_INDEX-1:0]  issue_qj;
    logic [FU_INDEX-1:0]  issue_qk;
    logic [FU_INDEX-1:0]  issue_tag;
    logic                 cdb_valid;
    logic [FU_INDEX-1:0]  cdb_tag;
    logic [WORD_SIZE-1:0] cdb_data;
    logic                 ex_valid;
    logic                 ex_ready;
    logic [OP_WIDTH-1:0]  ex_op;
    logic [WORD_SIZE-1:0] ex_a;
    logic [WORD_SIZE-1:0] ex_b;
    logic [FU_INDEX-1:0]  ex_tag;
    logic                 full;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        output cdb_valid, cdb_tag, cdb_data, ex_ready,
        input  issue_ready, issue_tag, ex_valid, ex_op, ex_a, ex_b, ex_tag, full
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        input  cdb_valid, cdb_tag, cdb_data, ex_ready,
        output issue_ready, issue_tag, ex_valid, ex_op, ex_a, ex_b, ex_tag, full
    );

endinterface
`default_nettype wire

// File: rtl/reservation_station_rs_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rs_select                                                  |
// | Desc    : Oldest-ready picker; greatest age wins, ties to low index. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rs_select
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [DEPTH-1:0]            i_ready,
    input  wire logic [DEPTH-1:0][AGE_W-1:0] i_age,
    output logic                             o_valid,
    output logic [DEPTH-1:0]                 o_grant,
    output logic [IDX_W-1:0]                 o_index
);

    logic [AGE_W-1:0] w_best;

    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        o_grant = '0;
        w_best  = '0;
        // Strict compare keeps the lowest index on equal ages.
        for (int i = 0; i < DEPTH; i++) begin
            if (i_ready[i] && (!o_valid || (i_age[i] > w_best))) begin
                o_valid = 1'b1;
                w_best  = i_age[i];
                o_index = IDX_W'(i);
            end
        end
        o_grant[o_index] = o_valid;
    end

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reservation_station                                        |
// | Desc    : Tomasulo station: issue, CDB wakeup, oldest-ready dispatch.|
// |           Optional flush port enabled by macro RS_FLUSH_EN.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module reservation_station #(
    parameter int WORD_SIZE = reservation_station_pkg::WORD_SIZE,
    parameter int FU_INDEX  = reservation_station_pkg::FU_INDEX,
    parameter int OP_WIDTH  = reservation_station_pkg::OP_WIDTH,
    parameter int DEPTH     = reservation_station_pkg::RS_DEPTH,
    parameter int BASE_TAG  = reservation_station_pkg::RS_ALU_BASE_TAG
) (
    input  wire logic            clk,
    input  wire logic            reset,
`ifdef RS_FLUSH_EN
    input  wire logic            flush,
`endif
    reservation_station_if.slave bus
);
    import reservation_station_pkg::*;

    localparam int                  c_idx_w   = $clog2(DEPTH);
    localparam logic [AGE_W-1:0]    c_age_max = AGE_W'(DEPTH - 1);
    localparam logic [FU_INDEX-1:0] c_ready   = FU_INDEX'(READY);

    logic [DEPTH-1:0]            r_busy;
    logic [DEPTH-1:0][AGE_W-1:0] r_age;
    logic [OP_WIDTH-1:0]         r_op [DEPTH];
    logic [WORD_SIZE-1:0]        r_vj [DEPTH];
    logic [WORD_SIZE-1:0]        r_vk [DEPTH];
    logic [FU_INDEX-1:0]         r_qj [DEPTH];
    logic [FU_INDEX-1:0]         r_qk [DEPTH];
    logic                        r_lock;
    logic [c_idx_w-1:0]          r_lock_idx;
    logic [DEPTH-1:0]            r_lock_oh;

    logic [DEPTH-1:0]   w_rdy;
    logic [c_idx_w-1:0] w_free_idx;
    logic               w_full;
    logic               w_issue;
    logic               w_pick_valid;
    logic [DEPTH-1:0]   w_pick_oh;
    logic [c_idx_w-1:0] w_pick_idx;
    logic [c_idx_w-1:0] w_sel_idx;
    logic [DEPTH-1:0]   w_sel_oh;
    logic               w_ex_valid;
    logic               w_dispatch;
    logic               w_byp_j;
    logic               w_byp_k;

    always_comb begin
        w_free_idx = '0;
        w_rdy      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_idx = c_idx_w'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy[i] = r_busy[i] && (r_qj[i] == c_ready) && (r_qk[i] == c_ready);
        end
    end

    rs_select #(
        .DEPTH (DEPTH),
        .IDX_W (c_idx_w)
    ) u_select (
        .i_ready (w_rdy),
        .i_age   (r_age),
        .o_valid (w_pick_valid),
        .o_grant (w_pick_oh),
        .o_index (w_pick_idx)
    );

    assign w_full = &r_busy;
`ifdef RS_FLUSH_EN
    assign bus.issue_ready = !w_full && !flush;
    assign w_ex_valid      = w_pick_valid && !flush;
`else
    assign bus.issue_ready = !w_full;
    assign w_ex_valid      = w_pick_valid;
`endif
    assign w_issue    = bus.issue_valid && bus.issue_ready;
    // A stalled grant is pinned so a later wakeup of an older entry cannot steal it.
    assign w_sel_idx  = r_lock ? r_lock_idx : w_pick_idx;
    assign w_sel_oh   = r_lock ? r_lock_oh  : w_pick_oh;
    assign w_dispatch = w_ex_valid && bus.ex_ready;

    assign bus.issue_tag = FU_INDEX'(BASE_TAG) + FU_INDEX'(w_free_idx);
    assign bus.full      = w_full;
    assign bus.ex_valid  = w_ex_valid;
    assign bus.ex_op     = w_ex_valid ? r_op[w_sel_idx] : '0;
    assign bus.ex_a      = w_ex_valid ? r_vj[w_sel_idx] : '0;
    assign bus.ex_b      = w_ex_valid ? r_vk[w_sel_idx] : '0;
    assign bus.ex_tag    = w_ex_valid ? FU_INDEX'(BASE_TAG) + FU_INDEX'(w_sel_idx) : '0;

    assign w_byp_j = bus.cdb_valid && (bus.issue_qj != c_ready) && (bus.cdb_tag == bus.issue_qj);
    assign w_byp_k = bus.cdb_valid && (bus.issue_qk != c_ready) && (bus.cdb_tag == bus.issue_qk);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy     <= '0;
            r_age      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_lock_oh  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_qj[i] <= c_ready;
                r_qk[i] <= c_ready;
            end
        end
`ifdef RS_FLUSH_EN
        else if (flush) begin
            r_busy <= '0;
            r_age  <= '0;
            r_lock <= 1'b0;
        end
`endif
        else begin
            r_lock     <= w_ex_valid && !bus.ex_ready;
            r_lock_idx <= w_sel_idx;
            r_lock_oh  <= w_sel_oh;
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.cdb_valid && r_busy[i] && (r_qj[i] != c_ready) && (r_qj[i] == bus.cdb_tag)) begin
                    r_vj[i] <= bus.cdb_data;
                    r_qj[i] <= c_ready;
                end
                if (bus.cdb_valid && r_busy[i] && (r_qk[i] != c_ready) && (r_qk[i] == bus.cdb_tag)) begin
                    r_vk[i] <= bus.cdb_data;
                    r_qk[i] <= c_ready;
                end
                if (w_dispatch && w_sel_oh[i]) begin
                    r_busy[i] <= 1'b0;
                end else if (w_issue && r_busy[i]) begin
                    r_age[i] <= age_inc(r_age[i], c_age_max);
                end
                if (w_issue && (w_free_idx == c_idx_w'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_age[i]  <= '0;
                    r_op[i]   <= bus.issue_op;
                    r_vj[i]   <= w_byp_j ? bus.cdb_data : bus.issue_vj;
                    r_vk[i]   <= w_byp_k ? bus.cdb_data : bus.issue_vk;
                    r_qj[i]   <= w_byp_j ? c_ready : bus.issue_qj;
                    r_qk[i]   <= w_byp_k ? c_ready : bus.issue_qk;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Tomasulo reservation station sitting directly downstream of reg_status.
- Accepts issued instructions whose operands arrive either as values or as producer FU tags, read from reg_status value*/status* outputs.
- Snoops the common data bus (CDB) to capture pending operands.
- Dispatches the oldest fully-ready entry to its functional unit.
- Returns the allocated entry tag, which the issue logic writes into reg_status via write_rs_status.

Parameters:
- WORD_SIZE, 32, operand/result width
- FU_INDEX, 4, tag width; tag value READY (0) means "operand valid"
- OP_WIDTH, 4, opcode width
- DEPTH, 4, number of entries (2..8)
- BASE_TAG, 1, tag of entry 0; entry i owns tag BASE_TAG+i (must not wrap to READY)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- issue_valid  in  1  issue request
- issue_ready  out  1  free entry available
- issue_op  in  OP_WIDTH  opcode
- issue_vj, issue_vk  in  WORD_SIZE  operand values (used when matching q is READY)
- issue_qj, issue_qk  in  FU_INDEX  producer tags from reg_status
- issue_tag  out  FU_INDEX  tag of the entry that will be allocated this cycle
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  FU_INDEX  producing tag
- cdb_data  in  WORD_SIZE  result
- ex_valid  out  1  dispatch request to FU
- ex_ready  in  1  FU accepts
- ex_op  out  OP_WIDTH  opcode
- ex_a, ex_b  out  WORD_SIZE  operands
- ex_tag  out  FU_INDEX  tag of dispatched entry (FU broadcasts it on CDB)
- full  out  1  all entries busy

Behaviour:
- Per-entry state: busy, op, vj, vk, qj, qk, age (3 bits).
- Reset (reset==0 at posedge):
  - all busy=0, qj=qk=READY, ages=0.
  - Outputs after reset: issue_ready=1, full=0, ex_valid=0, issue_tag=BASE_TAG.
  - ex_* data outputs are 0.
  - Reset overrides issue, CDB and dispatch in the same cycle; in-flight entries are discarded.
- Issue:
  - Lowest-index free entry is chosen.
  - issue_tag = BASE_TAG + that index, combinational.
  - issue_ready = !full, computed from current occupancy only. An entry freed by dispatch this cycle is reusable next cycle.
  - On issue_valid && issue_ready: entry becomes busy with age 0 and the other busy entries' ages increment, saturating at DEPTH-1.
- Issue/CDB bypass:
  - If cdb_valid and cdb_tag == issue_qj (!= READY) in the issue cycle: store vj=cdb_data, qj=READY.
  - Same rule for k.
  - No wakeup may be lost.
- Wakeup: each busy entry with qj==cdb_tag (and qj != READY) captures cdb_data into vj and sets qj=READY on the same edge. Same rule for k.
- Readiness: busy && qj==READY && qk==READY, evaluated on registered state. An entry woken at edge N is dispatchable from cycle N+1 (no CDB-to-ex combinational path).
- Dispatch:
  - ex_valid=1 when any entry is ready.
  - Selection picks the greatest age; ties go to the lowest index.
  - ex_* is driven combinationally from the selected entry.
  - Selection must stay stable while ex_valid && !ex_ready, unless a reset occurs.
  - On ex_valid && ex_ready: entry busy=0.
- Simultaneous issue + dispatch: both occur; the age update skips the departing entry.
- full = all busy.
- CDB with tag matching no entry: ignored.

Optional Feature:
- Macro RS_FLUSH_EN.
- When defined: extra input port flush (1 bit). flush==1 at posedge clears all busy bits and ages, like reset but leaves data fields untouched. Issue and dispatch are suppressed in that cycle (issue_ready=0, ex_valid=0 while flush==1). Reset has priority over flush.
- Without the macro: no port, no logic.

Decomposition:
- Shared package gets the existing parameters: WORD_SIZE, FU_INDEX, READY, plus OP_WIDTH and the RS tag base constants for each station instance.
- One natural sub-module, rs_select: combinational oldest-ready picker over DEPTH age/ready vectors, producing a one-hot grant and the index.

Test Plan:
- Reset then issue op=3, qj=qk=0, vj=5, vk=7 with ex_ready=1 -> issue_tag=1; next cycle ex_valid=1, ex_a=5, ex_b=7, ex_tag=1; entry freed after.
- Issue qj=9, vk=2 (qk=0); two cycles later cdb_valid, tag=9, data=0x10 -> ex_valid rises the cycle after the CDB edge with ex_a=0x10.
- Issue with qj=9 while cdb_valid, tag=9, data=0xAA the same cycle -> entry stores 0xAA, ready next cycle (bypass).
- Fill 4 entries with ex_ready=0 -> full=1, issue_ready=0; issue_valid ignored. Then ex_ready=1 for one cycle -> issue_ready=1 the next cycle only.
- Entries 0 (older) and 2 (newer) both ready -> entry 0 dispatched first. Hold ex_ready=0 and wake entry 1 -> ex_tag stays 1 (BASE_TAG+0).
- Drive reset low mid-operation with 3 busy entries and CDB active -> next cycle full=0, ex_valid=0, issue_tag=1. With RS_FLUSH_EN, flush=1 gives the same result.
